// File: rtl/tl_rx_ecrc_checker_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tl_rx_ecrc_checker_pipe                                        |
// | Purpose  : Two-stage pipelined ECRC (CRC-32) checker for received TLPs.   |
// |            Stage 1 masks and registers each beat: it forces the variant   |
// |            bits, records the lane mask and captures the digest. Stage 2   |
// |            folds the included lanes into the running CRC and raises a     |
// |            one-cycle result strobe two cycles after the EOP beat.         |
// | Ports    : i_clk, i_n_rst (async, active-low)                             |
// |            i_valid/i_sop/i_eop/i_data/i_len : beat stream, no backpressure|
// |            i_chk_en     : ECRC check enable, sampled on the EOP beat      |
// |            o_res_valid  : one-cycle result strobe                         |
// |            o_ecrc_error : digest mismatch, qualified by o_res_valid       |
// |            o_proto_err  : one-cycle pulse on a framing violation          |
// |            o_busy       : a packet is being accumulated                   |
// | Options  : ECRC_CHK_STATS_EN adds i_stat_clr, o_err_cnt and o_pkt_cnt.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tl_rx_ecrc_checker_pipe #(
   parameter int BUS_DW = 8,
   parameter int LEN_W  = $clog2(BUS_DW),
   parameter int EP_BIT = 22,
   parameter int TD_BIT = 23
) (
   input  logic                 i_clk,
   input  logic                 i_n_rst,
   input  logic                 i_valid,
   input  logic                 i_sop,
   input  logic                 i_eop,
   input  logic [32*BUS_DW-1:0] i_data,
   input  logic [LEN_W-1:0]     i_len,
   input  logic                 i_chk_en,
   output logic                 o_res_valid,
   output logic                 o_ecrc_error,
   output logic                 o_proto_err,
   output logic                 o_busy
`ifdef ECRC_CHK_STATS_EN
   ,
   input  logic                 i_stat_clr,
   output logic [15:0]          o_err_cnt,
   output logic [15:0]          o_pkt_cnt
`endif
);

   localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
   localparam logic [31:0] CRC_SEED  = 32'hFFFFFFFF;
   // Lane 0 sits in the MSBs of the beat.
   localparam int          LANE0_LSB = 32 * (BUS_DW - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   state_t state;

   // One DW through the CRC, MSB first. The loop unrolls into a pure XOR
   // network; nothing here iterates over clock cycles.
   function automatic logic [31:0] crc32_dw(input logic [31:0] crc_in,
                                            input logic [31:0] dw);
      logic [31:0] c;
      c = crc_in;
      for (int b = 31; b >= 0; b--) begin
         if (c[31] ^ dw[b]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else               c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   // ---------------------------------------------------------------- stage 1
   logic                 live;
   logic [32*BUS_DW-1:0] beat_masked;
   logic [BUS_DW-1:0]    lane_mask;
   logic [31:0]          digest;

   // A beat belongs to a packet if it opens one, or continues an open one.
   assign live = i_valid && (i_sop || (state == ST_ACC));

   always_comb begin
      beat_masked = i_data;
      lane_mask   = '0;
      digest      = '0;
      if (i_sop) begin
         beat_masked[LANE0_LSB + EP_BIT] = 1'b1;
         beat_masked[LANE0_LSB + TD_BIT] = 1'b1;
      end
      for (int k = 0; k < BUS_DW; k++) begin
         // On EOP only lanes below i_len carry data; lane i_len is the digest.
         if (!i_eop || (LEN_W'(k) < i_len)) lane_mask[k] = 1'b1;
         else beat_masked[32*(BUS_DW-1-k) +: 32] = '0;
         if (LEN_W'(k) == i_len) digest = i_data[32*(BUS_DW-1-k) +: 32];
      end
   end

   logic                 s1_valid;
   logic                 s1_sop;
   logic                 s1_eop;
   logic                 s1_chk_en;
   logic [32*BUS_DW-1:0] s1_data;
   logic [BUS_DW-1:0]    s1_mask;
   logic [31:0]          s1_digest;

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         s1_valid  <= 1'b0;
         s1_sop    <= 1'b0;
         s1_eop    <= 1'b0;
         s1_chk_en <= 1'b0;
         s1_data   <= '0;
         s1_mask   <= '0;
         s1_digest <= '0;
      end else begin
         s1_valid <= live;
         if (live) begin
            s1_sop    <= i_sop;
            s1_eop    <= i_eop;
            s1_chk_en <= i_chk_en;
            s1_data   <= beat_masked;
            s1_mask   <= lane_mask;
            s1_digest <= digest;
         end
      end
   end

   // Framing FSM. It tracks the input side so violations are flagged as
   // soon as the offending beat is sampled.
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         state       <= ST_IDLE;
         o_busy      <= 1'b0;
         o_proto_err <= 1'b0;
      end else begin
         o_proto_err <= 1'b0;
         if (i_valid) begin
            if (i_sop) begin
               // A new SOP always restarts; an open packet is abandoned.
               o_proto_err <= (state == ST_ACC);
               state       <= i_eop ? ST_IDLE : ST_ACC;
               o_busy      <= !i_eop;
            end else if (state == ST_IDLE) begin
               o_proto_err <= 1'b1;
            end else if (i_eop) begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [31:0] acc;
   logic [31:0] crc_next;

   always_comb begin
      crc_next = s1_sop ? CRC_SEED : acc;
      for (int k = 0; k < BUS_DW; k++) begin
         if (s1_mask[k]) crc_next = crc32_dw(crc_next, s1_data[32*(BUS_DW-1-k) +: 32]);
      end
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         acc          <= CRC_SEED;
         o_res_valid  <= 1'b0;
         o_ecrc_error <= 1'b0;
      end else begin
         o_res_valid  <= s1_valid && s1_eop;
         o_ecrc_error <= s1_valid && s1_eop && s1_chk_en && (crc_next != s1_digest);
         if (s1_valid) acc <= crc_next;
      end
   end

`ifdef ECRC_CHK_STATS_EN
   // Saturating counters; clear wins over a same-cycle increment.
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         o_err_cnt <= '0;
         o_pkt_cnt <= '0;
      end else if (i_stat_clr) begin
         o_err_cnt <= '0;
         o_pkt_cnt <= '0;
      end else begin
         if (o_res_valid && (o_pkt_cnt != 16'hFFFF)) o_pkt_cnt <= o_pkt_cnt + 16'd1;
         if (o_res_valid && o_ecrc_error && (o_err_cnt != 16'hFFFF))
            o_err_cnt <= o_err_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_rx_ecrc_checker_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tl_rx_ecrc_checker_pipe                                     |
// | Purpose  : Self-checking bench for tl_rx_ecrc_checker_pipe. A packet-     |
// |            level reference model predicts result strobes and framing      |
// |            pulses into queues; a monitor pops and compares them.          |
// | Options  : ECRC_CHK_STATS_EN also checks the statistics counters.         |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_tl_rx_ecrc_checker_pipe;

   localparam int BUS_DW = 8;
   localparam int LEN_W  = $clog2(BUS_DW);
   localparam int EP_BIT = 22;
   localparam int TD_BIT = 23;
   localparam int W      = 32 * BUS_DW;

   logic             clk    = 1'b0;
   logic             n_rst  = 1'b0;
   logic             valid  = 1'b0;
   logic             sop    = 1'b0;
   logic             eop    = 1'b0;
   logic             chk_en = 1'b0;
   logic [W-1:0]     data   = '0;
   logic [LEN_W-1:0] len    = '0;
   logic             res_valid, ecrc_error, proto_err, busy;
`ifdef ECRC_CHK_STATS_EN
   logic             stat_clr = 1'b0;
   logic [15:0]      err_cnt, pkt_cnt;
   int               m_pkt = 0;
   int               m_err = 0;
`endif

   tl_rx_ecrc_checker_pipe #(
      .BUS_DW (BUS_DW),
      .LEN_W  (LEN_W),
      .EP_BIT (EP_BIT),
      .TD_BIT (TD_BIT)
   ) dut (
      .i_clk        (clk),
      .i_n_rst      (n_rst),
      .i_valid      (valid),
      .i_sop        (sop),
      .i_eop        (eop),
      .i_data       (data),
      .i_len        (len),
      .i_chk_en     (chk_en),
      .o_res_valid  (res_valid),
      .o_ecrc_error (ecrc_error),
      .o_proto_err  (proto_err),
      .o_busy       (busy)
`ifdef ECRC_CHK_STATS_EN
      ,
      .i_stat_clr   (stat_clr),
      .o_err_cnt    (err_cnt),
      .o_pkt_cnt    (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ------------------------------------------------------ reference model
   typedef struct {
      int   at;
      logic err;
   } res_t;

   res_t        exp_res[$];
   int          exp_proto[$];
   bit          in_pkt = 0;
   logic [31:0] pkt_dws[$];
   logic [W-1:0] pkt[$];

   // CRC-32, poly 04C11DB7, seed FFFFFFFF, DW-at-a-time MSB-first division.
   function automatic logic [31:0] crc_ref(input logic [31:0] dws[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (dws[i]) begin
         c = c ^ dws[i];
         repeat (32) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] lane_of(input logic [W-1:0] b, input int k);
      return b[32*(BUS_DW-1-k) +: 32];
   endfunction

   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] b;
      for (int k = 0; k < BUS_DW; k++) b[32*k +: 32] = $urandom;
      return b;
   endfunction

   // Called at posedge+1: drives one valid beat and predicts its effects.
   task automatic send_beat(input logic s, input logic e, input logic [W-1:0] d,
                            input logic [LEN_W-1:0] l, input logic ce);
      logic [31:0] dw;
      int          n;
      valid = 1'b1; sop = s; eop = e; data = d; len = l; chk_en = ce;
      if (s) begin
         if (in_pkt) exp_proto.push_back(cyc + 1);
         pkt_dws.delete();
         in_pkt = 1;
      end else if (!in_pkt) begin
         exp_proto.push_back(cyc + 1);
      end
      if (in_pkt) begin
         n = e ? int'(l) : BUS_DW;
         for (int k = 0; k < n; k++) begin
            dw = lane_of(d, k);
            if (s && k == 0) begin
               dw[EP_BIT] = 1'b1;
               dw[TD_BIT] = 1'b1;
            end
            pkt_dws.push_back(dw);
         end
         if (e) begin
            exp_res.push_back('{at: cyc + 2,
                                err: (crc_ref(pkt_dws) != lane_of(d, int'(l))) && ce});
            in_pkt = 0;
         end
      end
      @(posedge clk); #1;
      valid = 1'b0; sop = 1'($urandom); eop = 1'($urandom); data = rand_beat();
   endtask

   // Invalid cycles carry random junk that must be ignored.
   task automatic idle(input int n);
      repeat (n) begin
         valid = 1'b0; sop = 1'($urandom); eop = 1'($urandom);
         data = rand_beat(); len = LEN_W'($urandom); chk_en = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic new_pkt(input int nb);
      pkt.delete();
      repeat (nb) pkt.push_back(rand_beat());
   endtask

   // Writes the golden digest (xor flip) into lane l of the last beat.
   task automatic seal(input int l, input logic [31:0] flip);
      logic [31:0]  dws[$];
      logic [31:0]  dw;
      logic [W-1:0] tmp;
      int           last;
      last = pkt.size() - 1;
      for (int b = 0; b <= last; b++) begin
         for (int k = 0; k < ((b == last) ? l : BUS_DW); k++) begin
            dw = lane_of(pkt[b], k);
            if (b == 0 && k == 0) begin
               dw[EP_BIT] = 1'b1;
               dw[TD_BIT] = 1'b1;
            end
            dws.push_back(dw);
         end
      end
      tmp = pkt[last];
      tmp[32*(BUS_DW-1-l) +: 32] = crc_ref(dws) ^ flip;
      pkt[last] = tmp;
   endtask

   task automatic send_pkt(input int l, input logic ce, input int gap_pct);
      int last;
      last = pkt.size() - 1;
      for (int b = 0; b <= last; b++) begin
         if (b == last) send_beat(b == 0, 1'b1, pkt[b], LEN_W'(l), ce);
         else           send_beat(b == 0, 1'b0, pkt[b], LEN_W'($urandom), 1'($urandom));
         if (b < last && int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(2, 1)));
      end
   endtask

   task automatic set_hdr_bit(input int bit_idx, input logic v);
      logic [W-1:0] tmp;
      tmp = pkt[0];
      tmp[32*(BUS_DW-1) + bit_idx] = v;
      pkt[0] = tmp;
   endtask

   // --------------------------------------------------------------- monitor
   res_t r;
   always @(negedge clk) begin
      if (n_rst) begin
         if (res_valid) begin
            if (exp_res.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_result: strobe with nothing expected (cycle %0d)", cyc);
            end else begin
               r = exp_res.pop_front();
               check("result_cycle", cyc, r.at);
               check("ecrc_error", ecrc_error, r.err);
`ifdef ECRC_CHK_STATS_EN
               m_pkt++;
               if (r.err) m_err++;
`endif
            end
         end else begin
            check("error_qualified", ecrc_error, 0);
         end
         while (exp_res.size() != 0 && exp_res[0].at < cyc) begin
            n_chk++;
            $display("FAIL missing_result: got none expected strobe at cycle %0d", exp_res[0].at);
            void'(exp_res.pop_front());
         end
         if (proto_err) begin
            if (exp_proto.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_proto_err: pulse with nothing expected (cycle %0d)", cyc);
            end else begin
               check("proto_err_cycle", cyc, exp_proto.pop_front());
            end
         end
         while (exp_proto.size() != 0 && exp_proto[0] < cyc) begin
            n_chk++;
            $display("FAIL missing_proto_err: got none expected pulse at cycle %0d", exp_proto[0]);
            void'(exp_proto.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // -------------------------------------------------------------- stimulus
   int          nb, l, sel;
   logic        ce;
   logic [31:0] fl;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_res_valid", res_valid, 0);
      check("reset_proto_err", proto_err, 0);
      check("reset_ecrc_error", ecrc_error, 0);
      n_rst = 1'b1;
      idle(2);

      // single-beat TLP, digest in lane 3
      new_pkt(1); seal(3, 32'h0); send_pkt(3, 1'b1, 0);
      idle(3);

      // digest-only EOP and top-lane digest
      new_pkt(1); seal(0, 32'h0); send_pkt(0, 1'b1, 0);
      new_pkt(2); seal(BUS_DW - 1, 32'h0); send_pkt(BUS_DW - 1, 1'b1, 0);
      idle(3);

`ifdef ECRC_CHK_STATS_EN
      stat_clr = 1'b1; m_pkt = 0; m_err = 0;
      @(posedge clk); #1;
      stat_clr = 1'b0;
`endif
      // 3-beat TLP, digest bit 0 flipped
      new_pkt(3); seal(5, 32'h1); send_pkt(5, 1'b1, 0);
      idle(3);
`ifdef ECRC_CHK_STATS_EN
      check("err_cnt_single", err_cnt, 1);
      check("pkt_cnt_single", pkt_cnt, 1);
`endif

      // EP / TD variant bits must not change the CRC
      new_pkt(2); set_hdr_bit(EP_BIT, 1'b0); seal(4, 32'h0); send_pkt(4, 1'b1, 0);
      set_hdr_bit(EP_BIT, 1'b1); send_pkt(4, 1'b1, 0);
      set_hdr_bit(TD_BIT, 1'b0); send_pkt(4, 1'b1, 0);
      idle(3);

      // back-to-back: gapped 3-beat TLP, then single-beat TLP with no gap
      new_pkt(3); seal(2, 32'h0); send_pkt(2, 1'b1, 100);
      new_pkt(1); seal(6, 32'h0); send_pkt(6, 1'b1, 0);
      check("busy_after_pkt", busy, 0);
      idle(3);

      // SOP during ACC: old packet discarded, only the new one reports
      send_beat(1'b1, 1'b0, rand_beat(), LEN_W'(0), 1'b1);
      check("busy_in_acc", busy, 1);
      send_beat(1'b0, 1'b0, rand_beat(), LEN_W'(0), 1'b1);
      new_pkt(2); seal(3, 32'h0); send_pkt(3, 1'b1, 0);
      idle(2);
      // stray non-SOP beat while idle
      send_beat(1'b0, 1'b1, rand_beat(), LEN_W'(2), 1'b1);
      idle(2);
      // check disabled: bad digest reports no error
      new_pkt(2); seal(1, 32'h8000_0000); send_pkt(1, 1'b0, 0);
      idle(3);

      // reset between beats 1 and 2 of a TLP
      new_pkt(3); seal(4, 32'h0);
      send_beat(1'b1, 1'b0, pkt[0], LEN_W'(0), 1'b1);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_res_valid", res_valid, 0);
      in_pkt = 0;
      pkt_dws.delete();
`ifdef ECRC_CHK_STATS_EN
      m_pkt = 0; m_err = 0;
`endif
      @(posedge clk); @(posedge clk); #1;
      n_rst = 1'b1;
      idle(1);
      // leftover beats of the lost TLP are framing violations now
      send_beat(1'b0, 1'b0, pkt[1], LEN_W'(0), 1'b1);
      send_beat(1'b0, 1'b1, pkt[2], LEN_W'(4), 1'b1);
      new_pkt(2); seal(5, 32'h0); send_pkt(5, 1'b1, 0);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         nb  = int'($urandom_range(4, 1));
         l   = int'($urandom_range(BUS_DW - 1, 0));
         ce  = 1'($urandom);
         fl  = ($urandom_range(1) == 0) ? 32'h0 : (32'h1 << $urandom_range(31));
         sel = int'($urandom_range(19));
         if (sel == 0)      send_beat(1'b1, 1'b0, rand_beat(), LEN_W'($urandom), 1'b1);
         else if (sel == 1) send_beat(1'b0, 1'($urandom), rand_beat(), LEN_W'($urandom), 1'b1);
         new_pkt(nb); seal(l, fl); send_pkt(l, ce, 30);
         if ($urandom_range(1) == 1) idle(int'($urandom_range(3, 1)));
      end
      idle(5);

      check("results_drained", exp_res.size(), 0);
      check("proto_drained", exp_proto.size(), 0);
`ifdef ECRC_CHK_STATS_EN
      check("pkt_cnt_final", pkt_cnt, m_pkt);
      check("err_cnt_final", err_cnt, m_err);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tl_rx_ecrc_checker_pipe.md
TL_RX_ECRC_CHECKER_PIPE -- requirements
Module: tl_rx_ecrc_checker_pipe

Interface
REQ-001 SHALL have parameter BUS_DW, default 8: 32-bit DW lanes per beat; legal values 4, 8, 16.
REQ-002 SHALL have parameter LEN_W, default $clog2(BUS_DW): width of i_len.
REQ-003 SHALL have parameter EP_BIT, default 22: bit index of EP within header DW0.
REQ-004 SHALL have parameter TD_BIT, default 23: bit index of TD within header DW0.
REQ-005 SHALL have ports:
- i_clk  in  1  clock.
- i_n_rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  beat valid; no backpressure exists.
- i_sop  in  1  first beat of TLP; lane 0 holds header DW0.
- i_eop  in  1  last beat of TLP.
- i_data  in  32*BUS_DW  beat data; lane 0 occupies the MSBs.
- i_len  in  LEN_W  on EOP beat, lane index of the ECRC digest (0..BUS_DW-1).
- i_chk_en  in  1  cfg ECRC check enable.
- o_res_valid  out  1  one-cycle check-result strobe.
- o_ecrc_error  out  1  digest mismatch; qualified by o_res_valid.
- o_proto_err  out  1  one-cycle pulse on framing violation.
- o_busy  out  1  packet accumulation in progress.

Function
REQ-006 SHALL use CRC-32 polynomial 04C11DB7, seed FFFFFFFF, MSB-first within each DW, lane 0 first.
REQ-007 SHALL force bit EP_BIT and bit TD_BIT of lane 0 to 1 on every SOP beat before CRC calculation (variant bits).
REQ-008 SHALL include all BUS_DW lanes in the CRC on non-EOP beats.
REQ-009 SHALL include lanes 0..i_len-1 on the EOP beat; lane i_len is the digest, and lanes above i_len are ignored.
REQ-010 SHALL treat i_len=0 on an EOP beat as digest-only, with no data lanes included.
REQ-011 SHALL be a 2-stage pipeline:
- stage 1 registers the masked beat, the lane mask, sop, eop and the digest;
- stage 2 folds the beat into the accumulator through a parallel XOR network, with no serial per-bit loop.
REQ-012 SHALL assert o_res_valid exactly 2 cycles after the EOP beat is sampled, for exactly 1 cycle.
REQ-013 SHALL set o_ecrc_error = (final CRC != digest) && i_chk_en, where i_chk_en is sampled on the EOP beat.
REQ-014 SHALL keep o_ecrc_error at 0 whenever o_res_valid is 0.
REQ-015 SHALL implement FSM IDLE/ACC:
- IDLE -> ACC on valid&sop&!eop;
- IDLE stays IDLE on valid&sop&eop (result still produced);
- ACC -> IDLE on valid&eop;
- o_busy = (state==ACC).
REQ-016 SHALL accept back-to-back TLPs, with a SOP beat on the cycle immediately after an EOP beat, and produce one o_res_valid per TLP.
REQ-017 SHALL re-seed the accumulator on every SOP beat, independent of prior state.
REQ-018 SHALL handle SOP in ACC as follows:
- pulse o_proto_err;
- discard the old packet with no o_res_valid;
- restart on the new SOP.
REQ-019 SHALL ignore a valid beat without SOP in IDLE and pulse o_proto_err.
REQ-020 SHALL ignore beats with i_valid=0: the accumulator, FSM and pipeline hold, with no bubble effect on the result.

Reset
REQ-021 SHALL, on i_n_rst low, immediately reset:
- FSM to IDLE;
- accumulator to FFFFFFFF;
- pipeline valid flags to 0;
- all outputs to 0.
REQ-022 SHALL discard a TLP in flight at reset, with no result strobe after reset release.

Configuration
REQ-023 SHALL compile statistics when ECRC_CHK_STATS_EN is defined, adding:
- output o_err_cnt[15:0], counting o_res_valid&o_ecrc_error, saturating at FFFF;
- output o_pkt_cnt[15:0], counting o_res_valid, saturating at FFFF;
- input i_stat_clr, which zeroes both counters synchronously and takes priority over a simultaneous increment.
REQ-024 SHALL omit these ports and counters entirely when ECRC_CHK_STATS_EN is undefined; all other behaviour is identical.

Verification
REQ-025 SHALL cover single-beat TLP: sop=eop=1, i_len=3, golden digest in lane 3 -> o_res_valid at +2 cycles, o_ecrc_error=0.
REQ-026 SHALL cover 3-beat TLP, BUS_DW=8, i_len=5 on EOP, digest bit 0 flipped -> o_ecrc_error=1 for exactly 1 cycle; with stats, o_err_cnt=1 and o_pkt_cnt=1.
REQ-027 SHALL cover EP variant bits: same TLP sent with EP=0 and with EP=1, each with the same golden digest -> both results error-free.
REQ-028 SHALL cover back-to-back TLPs: two TLPs with no gap and i_valid gaps inside the first -> two strobes, the second 1 cycle after the first.
REQ-029 SHALL cover framing violations:
- SOP during ACC -> o_proto_err pulse, and only the second TLP's result appears;
- i_chk_en=0 with a bad digest -> o_ecrc_error=0.
REQ-030 SHALL cover reset mid-TLP: i_n_rst asserted between beats 1 and 2, then a clean TLP sent -> no spurious strobe, and the clean TLP checks error-free.
